// File: rtl/viterbi_pkg.sv
// Shared types and constants for the Viterbi error channel.
// Channel modes, burst FSM states and the LFSR polynomial.
package viterbi_pkg;

  typedef enum logic [1:0] {
    CH_PASS,
    CH_RANDOM,
    CH_BURST,
    CH_FORCE
  } ch_mode_t;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } burst_st_t;

  // x^32 + x^22 + x^2 + x + 1
  localparam logic [31:0] LFSR_POLY = 32'h8020_0003;

endpackage

// File: rtl/viterbi_lfsr.sv
// Galois LFSR with step enable and async active-low reset.
// Ports: clk, rst, en (advance one step), state (current value).
module viterbi_lfsr
  import viterbi_pkg::*;
#(
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED   = 32'hACE1_2B6D
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic [LFSR_W-1:0] state
);

  // An all-zero LFSR would lock up, so a zero seed becomes 1.
  localparam logic [LFSR_W-1:0] INIT =
    (SEED == '0) ? {{(LFSR_W-1){1'b0}}, 1'b1} : SEED;
  localparam logic [LFSR_W-1:0] POLY = LFSR_POLY[LFSR_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= INIT;
    end else if (en) begin
      state <= (state >> 1) ^ (state[0] ? POLY : '0);
    end
  end

endmodule

// File: rtl/viterbi_err_channel.sv
// Registered error-injecting channel: PASS/RANDOM/BURST/FORCE corruption.
// Ports: cfg_*, clr_i, valid_i/sym_i in; valid_o/sym_o/err_mask_o, counters out.
module viterbi_err_channel
  import viterbi_pkg::*;
#(
  parameter int                SYM_W  = 2,
  parameter int                LFSR_W = 32,
  parameter logic [LFSR_W-1:0] SEED   = 32'hACE1_2B6D,
  parameter int                CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       cfg_mode_i,
  input  logic [7:0]       cfg_thresh_i,
  input  logic [3:0]       cfg_burst_len_i,
  input  logic [SYM_W-1:0] cfg_force_mask_i,
  input  logic             clr_i,
  input  logic             valid_i,
  input  logic [SYM_W-1:0] sym_i,
  output logic             valid_o,
  output logic [SYM_W-1:0] sym_o,
  output logic [SYM_W-1:0] err_mask_o,
  output logic [CNT_W-1:0] bit_err_ct_o,
  output logic [CNT_W-1:0] sym_ct_o
);

  ch_mode_t          mode;
  burst_st_t         state;
  burst_st_t         state_nx;
  logic [LFSR_W-1:0] lfsr;
  logic              lfsr_unused;
  logic              hit;
  logic [SYM_W-1:0]  rm;
  logic [SYM_W-1:0]  mask;
  logic [SYM_W-1:0]  burst_mask;
  logic [3:0]        remain;
  logic [3:0]        len_m1;
  logic [CNT_W:0]    bit_sum;

  assign mode        = ch_mode_t'(cfg_mode_i);
  assign lfsr_unused = ^lfsr;

  viterbi_lfsr #(
    .LFSR_W (LFSR_W),
    .SEED   (SEED)
  ) u_lfsr (
    .clk   (clk),
    .rst   (rst),
    .en    (valid_i),
    .state (lfsr)
  );

  // A hit must flip at least one bit, so a zero draw becomes 1.
  always_comb begin
    hit = lfsr[7:0] < cfg_thresh_i;
    rm  = lfsr[8 +: SYM_W];
    if (rm == '0) rm = {{(SYM_W-1){1'b0}}, 1'b1};
  end

  assign len_m1 = (cfg_burst_len_i == 4'd0) ? 4'd0
                : cfg_burst_len_i - 4'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (mode != CH_BURST) begin
      state_nx = ST_IDLE;
    end else if (valid_i) begin
      unique case (state)
        ST_IDLE:  if (hit && len_m1 != 4'd0) state_nx = ST_BURST;
        ST_BURST: if (remain == 4'd1) state_nx = ST_IDLE;
        default:  state_nx = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mask = '0;
    if (valid_i) begin
      unique case (mode)
        CH_PASS:   mask = '0;
        CH_RANDOM: mask = hit ? rm : '0;
        CH_BURST:  mask = (state == ST_BURST) ? burst_mask
                        : (hit ? rm : '0);
        CH_FORCE:  mask = cfg_force_mask_i;
        default:   mask = '0;
      endcase
    end
  end

  // Remaining-length counter and the mask held for the whole burst.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      remain     <= '0;
      burst_mask <= '0;
    end else if (mode != CH_BURST) begin
      remain <= '0;
    end else if (valid_i) begin
      if (state == ST_IDLE) begin
        if (hit) begin
          remain     <= len_m1;
          burst_mask <= rm;
        end
      end else begin
        remain <= remain - 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      sym_o      <= '0;
      err_mask_o <= '0;
    end else begin
      valid_o    <= valid_i;
      err_mask_o <= mask;
      if (valid_i) sym_o <= sym_i ^ mask;
    end
  end

  assign bit_sum = {1'b0, bit_err_ct_o}
                 + (CNT_W+1)'($countones(mask));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sym_ct_o     <= '0;
      bit_err_ct_o <= '0;
    end else if (clr_i) begin
      sym_ct_o     <= '0;
      bit_err_ct_o <= '0;
    end else if (valid_i) begin
      if (sym_ct_o != '1) sym_ct_o <= sym_ct_o + 1'b1;
      bit_err_ct_o <= bit_sum[CNT_W] ? '1 : bit_sum[CNT_W-1:0];
    end
  end

endmodule

// File: tb/tb_viterbi_err_channel.sv
// Self-checking bench for viterbi_err_channel.
// Reference model plus vector table and directed sequences.
module tb_viterbi_err_channel;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] thresh = 8'd0;
  logic [3:0] blen = 4'd1;
  logic [1:0] fmask = 2'd0;
  logic       clr = 1'b0;
  logic       valid = 1'b0;
  logic [1:0] sym = 2'd0;

  logic        vo, vo4;
  logic [1:0]  so, so4, mo, mo4;
  logic [15:0] bc, sc;
  logic [3:0]  bc4, sc4;

  int n_checks = 0;
  int n_fail = 0;

  logic [31:0] m_lfsr;
  int          m_left;
  logic [1:0]  m_held;
  logic [1:0]  m_sym;
  int          m_b, m_s;
  logic [1:0]  last_mask;

  typedef struct {
    logic [1:0] md;
    logic [1:0] fm;
    logic [1:0] s;
    logic [1:0] exp_s;
    logic [1:0] exp_m;
  } vec_t;

  vec_t tbl[8];
  logic [1:0] rec1[50];
  logic [1:0] rec2[50];
  logic [1:0] brec[$];

  viterbi_err_channel dut (
    .clk(clk), .rst(rst), .cfg_mode_i(mode),
    .cfg_thresh_i(thresh), .cfg_burst_len_i(blen),
    .cfg_force_mask_i(fmask), .clr_i(clr),
    .valid_i(valid), .sym_i(sym), .valid_o(vo),
    .sym_o(so), .err_mask_o(mo),
    .bit_err_ct_o(bc), .sym_ct_o(sc)
  );

  viterbi_err_channel #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .cfg_mode_i(mode),
    .cfg_thresh_i(thresh), .cfg_burst_len_i(blen),
    .cfg_force_mask_i(fmask), .clr_i(clr),
    .valid_i(valid), .sym_i(sym), .valid_o(vo4),
    .sym_o(so4), .err_mask_o(mo4),
    .bit_err_ct_o(bc4), .sym_ct_o(sc4)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input int act,
                       input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int sat(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    valid = 1'b0;
    clr = 1'b0;
    #1;
    check("rst valid_o", int'(vo), 0);
    check("rst sym_o", int'(so), 0);
    check("rst err_mask", int'(mo), 0);
    check("rst bit_ct", int'(bc), 0);
    check("rst sym_ct", int'(sc), 0);
    check("rst bit_ct4", int'(bc4), 0);
    check("rst sym_ct4", int'(sc4), 0);
    m_lfsr = 32'hACE1_2B6D;
    m_left = 0;
    m_held = 2'd0;
    m_sym = 2'd0;
    m_b = 0;
    m_s = 0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic step(input logic v, input logic [1:0] s,
                      input logic c);
    logic [1:0] msk;
    logic [1:0] rm;
    logic       hit;
    @(negedge clk);
    valid = v;
    sym = s;
    clr = c;
    rm = m_lfsr[9:8];
    if (rm == 2'd0) rm = 2'd1;
    hit = m_lfsr[7:0] < thresh;
    msk = 2'd0;
    if (v) begin
      case (mode)
        2'd1: if (hit) msk = rm;
        2'd2: begin
          if (m_left > 0) begin
            msk = m_held;
            m_left--;
          end else if (hit) begin
            msk = rm;
            m_held = rm;
            m_left = (blen == 0) ? 0 : int'(blen) - 1;
          end
        end
        2'd3: msk = fmask;
        default: msk = 2'd0;
      endcase
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 32'h8020_0003 : 32'h0);
      m_sym = s ^ msk;
    end
    if (mode != 2'd2) m_left = 0;
    if (c) begin
      m_s = 0;
      m_b = 0;
    end else if (v) begin
      m_s = sat(m_s + 1);
      m_b = sat(m_b + $countones(msk));
    end
    @(posedge clk);
    #1;
    check("valid_o", int'(vo), int'(v));
    check("err_mask_o", int'(mo), int'(msk));
    check("sym_o", int'(so), int'(m_sym));
    check("sym_ct", int'(sc), m_s);
    check("bit_err_ct", int'(bc), m_b);
    last_mask = mo;
  endtask

  initial begin
    int errs;
    int bsum;
    tbl[0] = '{2'd3, 2'b11, 2'b01, 2'b10, 2'b11};
    tbl[1] = '{2'd3, 2'b11, 2'b01, 2'b10, 2'b11};
    tbl[2] = '{2'd3, 2'b11, 2'b01, 2'b10, 2'b11};
    tbl[3] = '{2'd3, 2'b11, 2'b01, 2'b10, 2'b11};
    tbl[4] = '{2'd3, 2'b01, 2'b00, 2'b01, 2'b01};
    tbl[5] = '{2'd3, 2'b10, 2'b11, 2'b01, 2'b10};
    tbl[6] = '{2'd0, 2'b11, 2'b10, 2'b10, 2'b00};
    tbl[7] = '{2'd3, 2'b00, 2'b11, 2'b11, 2'b00};

    do_reset();

    // PASS, 100 random symbols
    mode = 2'd0;
    for (int i = 0; i < 100; i++) step(1'b1, 2'($urandom), 1'b0);
    check("pass sym_ct", int'(sc), 100);
    check("pass bit_ct", int'(bc), 0);

    // FORCE vector table
    step(1'b0, 2'd0, 1'b1);
    bsum = 0;
    for (int i = 0; i < 8; i++) begin
      mode = tbl[i].md;
      fmask = tbl[i].fm;
      step(1'b1, tbl[i].s, 1'b0);
      bsum += $countones(tbl[i].exp_m);
      check("tbl sym_o", int'(so), int'(tbl[i].exp_s));
      check("tbl mask", int'(mo), int'(tbl[i].exp_m));
      if (i == 3) check("force bit_ct 8", int'(bc), 8);
    end
    check("tbl bit_ct", int'(bc), bsum);

    // clr wins over increment in the same cycle
    mode = 2'd3;
    fmask = 2'b11;
    step(1'b1, 2'b00, 1'b1);
    check("clr win sym", int'(sc), 0);
    check("clr win bit", int'(bc), 0);

    // RANDOM thresh 0: never an error
    mode = 2'd1;
    thresh = 8'h00;
    for (int i = 0; i < 1000; i++) step(1'b1, 2'($urandom), 1'b0);
    check("thr0 bit_ct", int'(bc), 0);

    // RANDOM thresh FF: nearly every symbol hit
    thresh = 8'hFF;
    errs = 0;
    for (int i = 0; i < 1000; i++) begin
      step(1'b1, 2'($urandom), 1'b0);
      if (last_mask != 2'd0) errs++;
    end
    check("thrFF >=990", int'(errs >= 990), 1);

    // BURST len 3 with gapped valid
    mode = 2'd2;
    blen = 4'd3;
    for (int i = 0; i < 60; i++) begin
      step(1'b1, 2'($urandom), 1'b0);
      brec.push_back(last_mask);
      step(1'b0, 2'($urandom), 1'b0);
      check("gap mask 0", int'(mo), 0);
    end
    if (brec[0] != 2'd0) begin
      check("burst held 1", int'(brec[1]), int'(brec[0]));
      check("burst held 2", int'(brec[2]), int'(brec[0]));
    end
    // random config churn incl. burst length 0
    for (int i = 0; i < 300; i++) begin
      if (($urandom % 16) == 0) begin
        mode = 2'($urandom);
        thresh = 8'($urandom);
        blen = 4'($urandom);
        fmask = 2'($urandom);
      end
      step(1'($urandom), 2'($urandom), (($urandom % 64) == 0));
    end

    // CNT_W=4 saturation
    do_reset();
    mode = 2'd3;
    fmask = 2'b11;
    for (int i = 0; i < 10; i++) step(1'b1, 2'($urandom), 1'b0);
    check("cnt4 bit sat", int'(bc4), 15);
    check("cnt4 sym", int'(sc4), 10);
    step(1'b0, 2'd0, 1'b1);
    check("cnt4 clr bit", int'(bc4), 0);
    check("cnt4 clr sym", int'(sc4), 0);

    // reset mid-burst restarts the same error sequence
    do_reset();
    mode = 2'd1;
    thresh = 8'h80;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 2'($urandom), 1'b0);
      rec1[i] = last_mask;
    end
    mode = 2'd2;
    blen = 4'd8;
    thresh = 8'hFF;
    for (int i = 0; i < 3; i++) step(1'b1, 2'($urandom), 1'b0);
    do_reset();
    mode = 2'd1;
    thresh = 8'h80;
    for (int i = 0; i < 50; i++) begin
      step(1'b1, 2'($urandom), 1'b0);
      rec2[i] = last_mask;
    end
    for (int i = 0; i < 50; i++)
      check("replay mask", int'(rec2[i]), int'(rec1[i]));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
